// File: rtl/ens_layer_boundary_reg.sv
// Registered valid/ready boundary between two LogicNets layers: a 2-entry skid
// buffer with a fully registered s_ready, plus frame and stall debug counters.
module ens_layer_boundary_reg #(
   parameter int WIDTH = 1024,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   input  logic             clear_stats,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   // Encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  main_q, main_d;
   logic [WIDTH-1:0]  skid_q, skid_d;
   logic              s_ready_q, s_ready_d;
   logic [CNT_W-1:0]  frame_q, frame_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              in_fire, out_fire;

   assign m_valid   = (state_q != EMPTY);
   assign m_data    = main_q;
   assign s_ready   = s_ready_q;
   assign occupancy = state_q;
   assign frame_cnt = frame_q;
   assign stall_cnt = stall_q;

   assign in_fire  = s_valid & s_ready_q;
   assign out_fire = m_valid & m_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_d  = s_data;
               state_d = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_d = s_data;
            end else if (in_fire) begin
               skid_d  = s_data;
               state_d = FULL;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // s_ready is low here, so only the drain side can move.
            if (out_fire) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      s_ready_d = (state_d != FULL);
   end

   always_comb begin
      frame_d = frame_q;
      stall_d = stall_q;
      if (clear_stats) begin
         frame_d = '0;
         stall_d = '0;
      end else begin
         if (out_fire) frame_d = frame_q + CNT_W'(1);
         if (m_valid && !m_ready && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         s_ready_q <= 1'b0;
         frame_q   <= '0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         s_ready_q <= s_ready_d;
         frame_q   <= frame_d;
         stall_q   <= stall_d;
      end
   end

endmodule
